// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential divider and its datapath.
//   S_IDLE/S_RUN/S_DONE : state encodings used by the divider FSM
//   DEFAULT_WIDTH       : default operand width
//   state_e             : FSM state type built on the encodings above
package seq_divider_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = S_IDLE,
    RUN  = S_RUN,
    DONE = S_DONE
  } state_e;

endpackage

// File: rtl/addsub_nbit.sv
// Ripple-carry add/sub chain built from 1-bit add/sub cells.
//   a, b  : N-bit operands
//   ctrl  : 0 = add, 1 = subtract (b is inverted inside each cell)
//   ci    : carry into bit 0 (tie to 1 together with ctrl=1 for a - b)
//   sum   : N-bit result
//   co    : carry out of the top bit; for a subtract, 1 means no borrow
module addsub_cell (
  input  logic a,
  input  logic b,
  input  logic ctrl,
  input  logic ci,
  output logic s,
  output logic co
);

  logic bx;

  assign bx = b ^ ctrl;
  assign s  = a ^ bx ^ ci;
  assign co = (a & bx) | (ci & (a ^ bx));

endmodule

module addsub_nbit
  import seq_divider_pkg::*;
#(
  parameter int N = DEFAULT_WIDTH + 1
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         ctrl,
  input  logic         ci,
  output logic [N-1:0] sum,
  output logic         co
);

  logic [N:0] carry;

  assign carry[0] = ci;
  assign co       = carry[N];

  for (genvar i = 0; i < N; i++) begin : g_cell
    addsub_cell u_cell (
      .a    (a[i]),
      .b    (b[i]),
      .ctrl (ctrl),
      .ci   (carry[i]),
      .s    (sum[i]),
      .co   (carry[i+1])
    );
  end

endmodule

// File: rtl/seq_divider.sv
// Iterative unsigned restoring divider, one quotient bit per clock.
//   clk, rst          : clock, asynchronous active-high reset
//   start             : request a division (accepted in IDLE or DONE)
//   dividend, divisor : operands, captured when start is accepted
//   busy              : division in progress
//   done              : one-cycle pulse when results are updated
//   quotient          : result, held until the next result
//   remainder         : result, held until the next result
//   div_by_zero       : last accepted divisor was zero
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start
// RUN   | one shift/trial-subtract step per edge, WIDTH steps total
// DONE  | results just registered, done pulse; start accepted here too
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  state_e           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   rem_p;
  logic [WIDTH-1:0] q_p;
  logic [WIDTH-1:0] dvs;

  logic [WIDTH:0]   r_shift;
  logic [WIDTH:0]   trial;
  logic             no_borrow;
  logic [WIDTH:0]   r_next;
  logic [WIDTH-1:0] q_next;
  logic             unused_rem_msb;

  // The partial remainder always stays below the divisor, so its MSB is
  // zero before each shift and shifting it out loses nothing.
  assign r_shift = {rem_p[WIDTH-1:0], q_p[WIDTH-1]};
  assign unused_rem_msb = rem_p[WIDTH];

  addsub_nbit #(
    .N (WIDTH + 1)
  ) u_addsub (
    .a    (r_shift),
    .b    ({1'b0, dvs}),
    .ctrl (1'b1),
    .ci   (1'b1),
    .sum  (trial),
    .co   (no_borrow)
  );

  assign r_next = no_borrow ? trial : r_shift;
  assign q_next = {q_p[WIDTH-2:0], no_borrow};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      rem_p       <= '0;
      q_p         <= '0;
      dvs         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            rem_p <= '0;
            q_p   <= dividend;
            dvs   <= divisor;
            cnt   <= '0;
            if (divisor == '0) begin
              // No iteration needed: publish the divide-by-zero result now.
              state       <= DONE;
              busy        <= 1'b0;
              done        <= 1'b1;
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              state       <= RUN;
              busy        <= 1'b1;
              div_by_zero <= 1'b0;
            end
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        RUN: begin
          rem_p <= r_next;
          q_p   <= q_next;
          cnt   <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            state     <= DONE;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b1;
            quotient  <= q_next;
            remainder <= r_next[WIDTH-1:0];
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
